// File: rtl/stream_checker_pkg.sv
// Shared types and helpers for the in-order stream scoreboard.
package stream_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam int SAT_W = 64;

    // Increment that sticks at max_value instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                 input logic [SAT_W-1:0] max_value);
        return (value >= max_value) ? value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/stream_checker_fifo.sv
// Expected-word FIFO with registered full/empty flags and a synchronous flush.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_full;
    logic              r_empty;

    logic              w_do_push;
    logic              w_do_pop;
    logic [AW:0]       w_count_nx;

    assign w_do_push  = push && !r_full;
    assign w_do_pop   = pop && !r_empty;
    assign w_count_nx = r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nx;
            r_full  <= (w_count_nx == (AW+1)'(DEPTH));
            r_empty <= (w_count_nx == '0);
        end
    end

endmodule

// File: rtl/stream_checker.sv
// In-order scoreboard: buffers expected words, compares each actual word
// against the oldest one, counts results and holds a sticky pass/fail verdict.
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  total,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              act_valid,
    output logic              act_ready,
    input  logic [DATA_W-1:0] act_data,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act,
    output chk_state_e        dbg_state
);
    localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    chk_state_e        r_state;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_checked;
    logic [CNT_W-1:0]  r_match_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic [CNT_W-1:0]  r_first_err_idx;
    logic [DATA_W-1:0] r_first_err_exp;
    logic [DATA_W-1:0] r_first_err_act;
    logic [TMR_W-1:0]  r_idle;
    logic              r_done;
    logic              r_pass;
    logic              r_fail;
    logic              r_timeout;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_head;
    logic              w_run;
    logic              w_start;
    logic              w_push;
    logic              w_pop;
    logic              w_mismatch;
    logic              w_last;
    logic              w_idle_exp;
    logic [CNT_W-1:0]  w_checked_nx;

    // A word transfers on a rising edge where valid && ready; ready never
    // depends on valid, and both streams are only accepted while in RUN.
    assign w_run        = (r_state == RUN);
    assign w_start      = start && !w_run;
    assign exp_ready    = w_run && !w_fifo_full;
    assign act_ready    = w_run && !w_fifo_empty;
    assign w_push       = exp_valid && exp_ready;
    assign w_pop        = act_valid && act_ready;
    assign w_mismatch   = (w_fifo_head != act_data);
    assign w_checked_nx = r_checked + CNT_W'(1);
    assign w_last       = (w_checked_nx == r_total);
    assign w_idle_exp   = (TIMEOUT != 0) && (r_idle == TMR_W'(TIMEOUT - 1));

    sync_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_exp_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (w_start),
        .push     (w_push),
        .push_data(exp_data),
        .pop      (w_pop),
        .pop_data (w_fifo_head),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_total         <= '0;
            r_checked       <= '0;
            r_match_cnt     <= '0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_first_err_exp <= '0;
            r_first_err_act <= '0;
            r_idle          <= '0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_fail          <= 1'b0;
            r_timeout       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_total         <= total;
                        r_checked       <= '0;
                        r_match_cnt     <= '0;
                        r_err_cnt       <= '0;
                        r_first_err_idx <= '0;
                        r_first_err_exp <= '0;
                        r_first_err_act <= '0;
                        r_idle          <= '0;
                        r_timeout       <= 1'b0;
                        r_fail          <= 1'b0;
                        if (total == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_done  <= 1'b0;
                            r_pass  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (w_pop) begin
                        r_idle    <= '0;
                        r_checked <= w_checked_nx;
                        if (w_mismatch) begin
                            r_err_cnt <= CNT_W'(sat_inc(SAT_W'(r_err_cnt), SAT_W'(CNT_MAX)));
                            if (r_err_cnt == '0) begin
                                r_first_err_idx <= r_checked;
                                r_first_err_exp <= w_fifo_head;
                                r_first_err_act <= act_data;
                            end
                        end else begin
                            r_match_cnt <= r_match_cnt + CNT_W'(1);
                        end
                        if (w_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_cnt == '0) && !w_mismatch;
                            r_fail  <= (r_err_cnt != '0) || w_mismatch;
                        end
                    end else if (w_idle_exp) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_fail    <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        r_idle <= r_idle + TMR_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign done          = r_done;
    assign pass          = r_pass;
    assign fail          = r_fail;
    assign timeout       = r_timeout;
    assign match_cnt     = r_match_cnt;
    assign err_cnt       = r_err_cnt;
    assign first_err_idx = r_first_err_idx;
    assign first_err_exp = r_first_err_exp;
    assign first_err_act = r_first_err_act;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: table of check runs plus hand-written
// sequences for reset, zero-length runs and the no-bypass corner.
module tb_stream_checker;
  import stream_checker_pkg::*;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 16;
  localparam int MAX_CYC = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  total;
  logic              exp_valid;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_data;
  logic              act_valid;
  logic              act_ready;
  logic [DATA_W-1:0] act_data;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  first_err_idx;
  logic [DATA_W-1:0] first_err_exp;
  logic [DATA_W-1:0] first_err_act;
  chk_state_e        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  stream_checker #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .total        (total),
    .exp_valid    (exp_valid),
    .exp_ready    (exp_ready),
    .exp_data     (exp_data),
    .act_valid    (act_valid),
    .act_ready    (act_ready),
    .act_data     (act_data),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .match_cnt    (match_cnt),
    .err_cnt      (err_cnt),
    .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp),
    .first_err_act(first_err_act),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0]      total;
    int                    n_exp;
    int                    n_act;
    int                    act_delay;
    int                    abort_at;
    logic [7:0][DATA_W-1:0] exp_w;
    logic [7:0][DATA_W-1:0] act_w;
    logic                  e_pass;
    logic                  e_timeout;
    logic [CNT_W-1:0]      e_match;
    logic [CNT_W-1:0]      e_err;
    logic [CNT_W-1:0]      e_idx;
    logic [DATA_W-1:0]     e_fexp;
    logic [DATA_W-1:0]     e_fact;
  } run_vec_t;

  run_vec_t vecs[7];

  function automatic logic [7:0][DATA_W-1:0] w8(input int a0, input int a1, input int a2,
                                                input int a3, input int a4, input int a5,
                                                input int a6, input int a7);
    logic [7:0][DATA_W-1:0] w;
    w[0] = a0; w[1] = a1; w[2] = a2; w[3] = a3;
    w[4] = a4; w[5] = a5; w[6] = a6; w[7] = a7;
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},     64'(dbg_state), 64'(IDLE));
    chk({tag, "_done"},      64'(done), 64'd0);
    chk({tag, "_pass"},      64'(pass), 64'd0);
    chk({tag, "_fail"},      64'(fail), 64'd0);
    chk({tag, "_timeout"},   64'(timeout), 64'd0);
    chk({tag, "_exp_ready"}, 64'(exp_ready), 64'd0);
    chk({tag, "_act_ready"}, 64'(act_ready), 64'd0);
    chk({tag, "_match"},     64'(match_cnt), 64'd0);
    chk({tag, "_err"},       64'(err_cnt), 64'd0);
    chk({tag, "_fidx"},      64'(first_err_idx), 64'd0);
    chk({tag, "_fexp"},      64'(first_err_exp), 64'd0);
    chk({tag, "_fact"},      64'(first_err_act), 64'd0);
  endtask

  // driver: start pulse issued from a negedge, sampled on the next posedge
  task automatic do_start(input logic [CNT_W-1:0] t);
    total = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // driver + scoreboard for one table row
  task automatic run_vec(input int r, input run_vec_t v);
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] head;
    int ei, ai, cyc, last_hs, model_err;
    logic hs_e, hs_a;
    string tag;
    tag = $sformatf("row%0d", r);
    ei = 0; ai = 0; cyc = 0; last_hs = -1; model_err = 0;
    do_start(v.total);
    while (!done && cyc < MAX_CYC) begin
      exp_valid = (ei < v.n_exp);
      exp_data  = (ei < 8) ? v.exp_w[ei[2:0]] : '0;
      act_valid = (ai < v.n_act) && (cyc >= v.act_delay);
      act_data  = (ai < 8) ? v.act_w[ai[2:0]] : '0;
      #1;
      if (v.act_delay > 0 && cyc == v.act_delay - 1) begin
        chk({tag, "_full_exp_ready"}, 64'(exp_ready), 64'd0);
        chk({tag, "_full_accepted"}, 64'(ei), 64'(DEPTH));
      end
      hs_e = exp_valid && exp_ready;
      hs_a = act_valid && act_ready;
      @(negedge clk);
      if (hs_a) begin
        head = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (head != act_data) model_err++;
        ai++;
        last_hs = cyc;
      end
      if (hs_e) begin
        exp_q.push_back(exp_data);
        ei++;
      end
      if (v.abort_at != 0 && ai == v.abort_at) begin
        exp_valid = 1'b0;
        act_valid = 1'b0;
        chk({tag, "_pre_abort_match"}, 64'(match_cnt), 64'(v.abort_at));
        rst = 1'b1;
        #1;
        chk_reset_vals({tag, "_abort"});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      if (!v.e_timeout && ai == int'(v.total)) begin
        chk({tag, "_done_latency"}, 64'(done), 64'd1);
      end
      cyc++;
    end
    exp_valid = 1'b0;
    act_valid = 1'b0;
    chk({tag, "_done_in_bound"}, 64'(done), 64'd1);
    if (v.e_timeout) begin
      chk({tag, "_timeout_latency"}, 64'(cyc - 1 - last_hs), 64'(TIMEOUT));
    end
    chk({tag, "_pass"},      64'(pass), 64'(v.e_pass));
    chk({tag, "_fail"},      64'(fail), 64'(!v.e_pass));
    chk({tag, "_timeout"},   64'(timeout), 64'(v.e_timeout));
    chk({tag, "_match"},     64'(match_cnt), 64'(v.e_match));
    chk({tag, "_err"},       64'(err_cnt), 64'(v.e_err));
    chk({tag, "_err_model"}, 64'(err_cnt), 64'(model_err));
    chk({tag, "_fidx"},      64'(first_err_idx), 64'(v.e_idx));
    chk({tag, "_fexp"},      64'(first_err_exp), 64'(v.e_fexp));
    chk({tag, "_fact"},      64'(first_err_act), 64'(v.e_fact));
    chk({tag, "_state"},     64'(dbg_state), 64'(DONE));
    chk({tag, "_exp_ready_done"}, 64'(exp_ready), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    total     = '0;
    exp_valid = 1'b0;
    exp_data  = '0;
    act_valid = 1'b0;
    act_data  = '0;

    vecs[0] = '{total: 8, n_exp: 8, n_act: 8, act_delay: 0, abort_at: 0,
                exp_w: w8(0, 1, 2, 3, 4, 5, 6, 7), act_w: w8(0, 1, 2, 3, 4, 5, 6, 7),
                e_pass: 1, e_timeout: 0, e_match: 8, e_err: 0, e_idx: 0, e_fexp: 0, e_fact: 0};
    vecs[1] = '{total: 4, n_exp: 4, n_act: 4, act_delay: 0, abort_at: 0,
                exp_w: w8('hA0, 'hB1, 'hC2, 'hD3, 0, 0, 0, 0),
                act_w: w8('hA0, 'hB1, 'hEE, 'hD3, 0, 0, 0, 0),
                e_pass: 0, e_timeout: 0, e_match: 3, e_err: 1, e_idx: 2, e_fexp: 'hC2, e_fact: 'hEE};
    vecs[2] = '{total: 6, n_exp: 6, n_act: 6, act_delay: 10, abort_at: 0,
                exp_w: w8(10, 11, 12, 13, 14, 15, 0, 0), act_w: w8(10, 11, 12, 13, 14, 15, 0, 0),
                e_pass: 1, e_timeout: 0, e_match: 6, e_err: 0, e_idx: 0, e_fexp: 0, e_fact: 0};
    vecs[3] = '{total: 5, n_exp: 5, n_act: 5, act_delay: 0, abort_at: 0,
                exp_w: w8(1, 2, 3, 4, 5, 0, 0, 0), act_w: w8(1, 9, 3, 8, 5, 0, 0, 0),
                e_pass: 0, e_timeout: 0, e_match: 3, e_err: 2, e_idx: 1, e_fexp: 2, e_fact: 9};
    vecs[4] = '{total: 3, n_exp: 3, n_act: 2, act_delay: 0, abort_at: 0,
                exp_w: w8(21, 22, 23, 0, 0, 0, 0, 0), act_w: w8(21, 22, 0, 0, 0, 0, 0, 0),
                e_pass: 0, e_timeout: 1, e_match: 2, e_err: 0, e_idx: 0, e_fexp: 0, e_fact: 0};
    vecs[5] = '{total: 8, n_exp: 8, n_act: 8, act_delay: 0, abort_at: 3,
                exp_w: w8(0, 1, 2, 3, 4, 5, 6, 7), act_w: w8(0, 1, 2, 3, 4, 5, 6, 7),
                e_pass: 0, e_timeout: 0, e_match: 0, e_err: 0, e_idx: 0, e_fexp: 0, e_fact: 0};
    vecs[6] = vecs[0];

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("post_reset");

    // zero-length run: done with pass one cycle after start
    do_start('0);
    chk("zero_done",  64'(done), 64'd1);
    chk("zero_pass",  64'(pass), 64'd1);
    chk("zero_fail",  64'(fail), 64'd0);
    chk("zero_state", 64'(dbg_state), 64'(DONE));
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      run_vec(r, vecs[r]);
    end

    // no bypass: a word pushed this cycle cannot be compared this cycle
    do_start(16'd1);
    exp_valid = 1'b1; exp_data = 32'h55;
    act_valid = 1'b1; act_data = 32'h55;
    #1;
    chk("nobypass_act_ready_empty", 64'(act_ready), 64'd0);
    chk("nobypass_exp_ready",       64'(exp_ready), 64'd1);
    @(negedge clk);
    exp_valid = 1'b0;
    #1;
    chk("nobypass_act_ready_next",  64'(act_ready), 64'd1);
    chk("nobypass_not_done_yet",    64'(done), 64'd0);
    @(negedge clk);
    act_valid = 1'b0;
    chk("nobypass_done",  64'(done), 64'd1);
    chk("nobypass_pass",  64'(pass), 64'd1);
    chk("nobypass_match", 64'(match_cnt), 64'd1);

    // start is ignored while running
    do_start(16'd2);
    do_start(16'd0);
    chk("start_in_run_ignored", 64'(dbg_state), 64'(RUN));
    chk("start_in_run_done",    64'(done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_checker.md
# stream_checker

Synthesizable in-order scoreboard. It compares a DUT's actual output stream against an expected-value stream, counts matches and mismatches, and raises a sticky pass/fail verdict. It sits directly upstream of the simulation report helpers: the bench waits for `done`, then calls the pass or fail banner based on `pass`/`fail`. It can also stay in silicon as a BIST result checker.

## Interface
Parameters:
- `DATA_W`, 32: width of the expected and actual data words.
- `DEPTH`, 16: expected-FIFO depth. Must be a power of two, ≥2.
- `CNT_W`, 16: width of the transaction counters and of `total`.
- `TIMEOUT`, 1024: idle cycles allowed in RUN without an actual handshake before the check aborts. 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a check run. Sampled only in IDLE or DONE.
- `total`  in  CNT_W  number of actual transactions to check. Sampled on `start`.
- `exp_valid`  in  1  expected-word valid.
- `exp_ready`  out  1  expected-word ready.
- `exp_data`  in  DATA_W  expected word.
- `act_valid`  in  1  actual-word valid.
- `act_ready`  out  1  actual-word ready.
- `act_data`  in  DATA_W  actual word from the DUT.
- `done`  out  1  run finished (count reached, or timeout).
- `pass`  out  1  `done` and no mismatches and no timeout.
- `fail`  out  1  `done` and (mismatches or timeout).
- `timeout`  out  1  run aborted by the idle timeout.
- `match_cnt`  out  CNT_W  number of matched compares.
- `err_cnt`  out  CNT_W  number of mismatched compares. Saturates at all-ones.
- `first_err_idx`  out  CNT_W  index (0-based) of the first mismatch. Valid when `err_cnt != 0`.
- `first_err_exp`, `first_err_act`  out  DATA_W  the two words involved in the first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start`:
  - clear all counters, the idle timer, and the first-error registers;
  - flush the FIFO;
  - latch `total`.
- If `total == 0` on `start`, go straight to DONE with `pass=1`.
- RUN behaviour:
  - `exp_ready = !fifo_full`.
  - `act_ready = !fifo_empty`. There is no bypass: an expected word pushed in cycle N can be compared in cycle N+1 at the earliest.
  - Actual handshake: pop the FIFO and compare the head with `act_data`. On equality, `match_cnt++`; otherwise `err_cnt++`.
  - On the first mismatch only, capture the checked index, the expected word, and the actual word.
- RUN → DONE when the checked count (`match_cnt + err_cnt`, tracked in a separate checked counter) reaches the latched `total`.
- RUN → DONE when the idle timer reaches `TIMEOUT`. This sets `timeout=1`.
- The idle timer resets on every actual handshake.
- DONE:
  - `done=1`;
  - `pass = (err_cnt==0) && !timeout`;
  - `fail = !pass`.
  - Verdict, counters and first-error registers hold.
- DONE → RUN on `start`, which re-arms exactly like IDLE → RUN.
- In IDLE and DONE, `exp_ready=0` and `act_ready=0`.
- `start` while in RUN is ignored.
- In RUN, push and pop can happen in the same cycle, including when the FIFO is full or empty:
  - full: pop is allowed, push is blocked because `exp_ready` uses the registered full flag;
  - empty: push is allowed, pop is blocked.
- Expected words left in the FIFO at DONE are discarded at the next `start`. They are not an error.

## Timing
- Reset values:
  - state IDLE;
  - all counters 0;
  - `done`, `pass`, `fail`, `timeout` all 0;
  - `exp_ready`, `act_ready` 0;
  - first-error registers 0;
  - FIFO empty.
- Compare result to counters: registered, 1 cycle after the handshake.
- `done` rises 1 cycle after the handshake that completes `total` compares.
- `pass`/`fail` are valid in the same cycle as `done`.
- Timeout: `done` rises exactly `TIMEOUT` cycles after the last actual handshake, or after `start` if no handshake occurred.
- `rst` during RUN aborts immediately to the reset values. No partial verdict is kept.

## Structure
- `stream_checker_pkg`:
  - state enum `chk_state_e {IDLE, RUN, DONE}`;
  - a helper function for saturating increment.
- Sub-module `sync_fifo`:
  - parameters DATA_W and DEPTH;
  - registered full/empty flags;
  - same `clk`/`rst` conventions.
- Top-level RTL: FSM, counters, timer, capture registers (~200 lines total).

## Test plan
- Matching stream: `total=8`, push 8 expected words 0..7, drive actual 0..7 → `done` 1 cycle after the 8th handshake; `pass=1`, `match_cnt=8`, `err_cnt=0`.
- Single mismatch: `total=4`, expected A,B,C,D, actual A,B,X,D → `fail=1`, `err_cnt=1`, `first_err_idx=2`, `first_err_exp=C`, `first_err_act=X`.
- Backpressure and full: DEPTH=4, push 6 expected with no actual traffic → `exp_ready=0` after 4 words. Start actual traffic → no word is lost or reordered and `pass=1`.
- Empty/no-bypass: FIFO empty, push expected and assert `act_valid` in the same cycle → `act_ready=0` that cycle, handshake happens the next cycle.
- Timeout: `TIMEOUT=16`, `total=3`, only 2 actual words → `done=1`, `timeout=1`, `fail=1`, `match_cnt=2`. Also: `total=0` → `done` with `pass` 1 cycle after `start`.
- Reset mid-run: assert `rst` after 3 of 8 compares → all outputs return to reset values. A new `start` with `total=8` runs clean and gives `pass=1`.
